// File: rtl/pipe_drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_drain_fifo
//  Purpose  : Receive-side circular FIFO at the output of a non-stallable,
//             fixed-latency FHE datapath pipeline. Every valid beat from the
//             pipeline is captured and presented downstream over valid/ready.
//             A credit counter bounds (in-flight + stored) beats to DEPTH so
//             the FIFO can never be overrun by a well-behaved issuer.
//  Options  : define PIPE_DRAIN_FIFO_ERR_EN to enable the sticky protocol
//             error flag (overflow push / issue without credit). Without
//             it, err is tied low and no checking logic is built.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_drain_fifo #(
    parameter int DATA_SIZE = 64,                  // FHE field size (FSIZE)
    parameter int DEPTH     = 8,                   // entries, >= 2, any value
    parameter int CW        = $clog2(DEPTH + 1)    // count / credit width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data,
    input  logic                 out_ready,
    output logic [CW-1:0]        count,
    output logic [CW-1:0]        credits,
    output logic                 err
);

    // Pointer width covers indices 0..DEPTH-1; DEPTH need not be a power of
    // two, so pointers wrap explicitly at LAST_IDX.
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        fill_level;
    logic [CW-1:0]        credit_level;

    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 issue;

    // Handshake decode. A push into a full FIFO is only accepted when the
    // head leaves in the same cycle; otherwise the beat is dropped.
    always_comb begin
        full  = (fill_level == FULL_LVL);
        pop   = (fill_level != '0) && out_ready;
        push  = in_valid && (!full || pop);
        issue = issue_valid && (credit_level != '0);
    end

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Write pointer advances on every accepted push, wrapping at DEPTH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
        end
    end

    // Read pointer advances on every pop, wrapping at DEPTH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Occupancy: push and pop together leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
        end
    end

    // Credits: consumed by an issue, returned by a pop, saturating at DEPTH.
    // An issue is only possible with a non-zero balance, so no underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_level <= FULL_LVL;
        end else begin
            case ({issue, pop})
                2'b10:   credit_level <= credit_level - 1'b1;
                2'b01:   credit_level <= (credit_level == FULL_LVL) ?
                                         credit_level : credit_level + 1'b1;
                default: credit_level <= credit_level;
            endcase
        end
    end

`ifdef PIPE_DRAIN_FIFO_ERR_EN
    logic err_flag;

    // Sticky error: overflow push without a pop, or an issue with no credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag <= 1'b0;
        end else if ((in_valid && full && !pop) ||
                     (issue_valid && (credit_level == '0))) begin
            err_flag <= 1'b1;
        end
    end

    assign err = err_flag;
`else
    assign err = 1'b0;
`endif

    // Output drive: head read combinationally, credits gate the issuer.
    assign out_valid   = (fill_level != '0);
    assign out_data    = mem[rd_ptr];
    assign count       = fill_level;
    assign credits     = credit_level;
    assign issue_ready = (credit_level != '0);

endmodule
`default_nettype wire

// File: tb/tb_pipe_drain_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pipe_drain_fifo
//  Purpose  : Self-checking bench for pipe_drain_fifo. Three instances
//             (DEPTH 8, 5, 4) share one stimulus stream and are each compared
//             every cycle against a list-based reference model; directed
//             literal checks pin the model at key points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_drain_fifo;

    localparam int NI = 3;

`ifdef PIPE_DRAIN_FIFO_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic       ir  [NI];
    logic       ov  [NI];
    logic [7:0] od  [NI];
    logic [3:0] cnt [NI];
    logic [3:0] crd [NI];
    logic       er  [NI];

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Reference model: stored beats as an ordered list (index 0 = head)
    int         m_cnt [NI];
    int         m_crd [NI];
    logic [7:0] m_dat [NI][16];
    bit         m_err [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int D = (k == 0) ? 8 : ((k == 1) ? 5 : 4);
        localparam int W = $clog2(D + 1);
        logic [W-1:0] c_w;
        logic [W-1:0] r_w;
        pipe_drain_fifo #(.DATA_SIZE(8), .DEPTH(D)) u_dut (
            .clk(clk), .rst(rst),
            .issue_valid(issue_valid), .issue_ready(ir[k]),
            .in_valid(in_valid), .in_data(in_data),
            .out_valid(ov[k]), .out_data(od[k]), .out_ready(out_ready),
            .count(c_w), .credits(r_w), .err(er[k])
        );
        assign cnt[k] = 4'(c_w);
        assign crd[k] = 4'(r_w);
    end

    function automatic int dep_of(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 5 : 4);
    endfunction

    task automatic check(input string nm, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual %0h required %0h", nm, k, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_cnt[k] = 0;
            m_crd[k] = dep_of(k);
            m_err[k] = 1'b0;
        end
    endtask

    // Applies the buffer's rules to the inputs sampled at this rising edge.
    task automatic model_update();
        for (int k = 0; k < NI; k++) begin
            int d;
            bit pop, iss, bad, acc, ovf;
            d   = dep_of(k);
            pop = (m_cnt[k] > 0) && out_ready;
            iss = issue_valid && (m_crd[k] > 0);
            bad = issue_valid && (m_crd[k] == 0);
            acc = in_valid && ((m_cnt[k] < d) || pop);
            ovf = in_valid && (m_cnt[k] == d) && !pop;
            if (rst) begin
                m_cnt[k] = 0;
                m_crd[k] = d;
                m_err[k] = 1'b0;
            end else begin
                if (pop) begin
                    for (int j = 0; j < 15; j++) m_dat[k][j] = m_dat[k][j+1];
                    m_cnt[k]--;
                end
                if (acc) begin
                    m_dat[k][m_cnt[k]] = in_data;
                    m_cnt[k]++;
                end
                m_crd[k] = m_crd[k] - int'(iss) + int'(pop);
                if (m_crd[k] > d) m_crd[k] = d;
                if (ERR_ON && (ovf || bad)) m_err[k] = 1'b1;
            end
        end
    endtask

    // One clock: model follows the edge, inputs may change 2ns later.
    task automatic step();
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic drive(input bit iv, input bit v, input logic [7:0] d, input bit r);
        issue_valid = iv;
        in_valid    = v;
        in_data     = d;
        out_ready   = r;
    endtask

    task automatic do_reset();
        drive(0, 0, 8'h00, 0);
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
    endtask

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < NI; k++) begin
                check("issue_ready", k, ir[k], (m_crd[k] != 0));
                check("out_valid", k, ov[k], (m_cnt[k] != 0));
                if (m_cnt[k] != 0) check("out_data", k, od[k], m_dat[k][0]);
                check("count", k, cnt[k], m_cnt[k]);
                check("credits", k, crd[k], m_crd[k]);
                check("err", k, er[k], m_err[k]);
            end
        end
    end

    initial begin
        logic [7:0] got [$];
        int sent;
        int guard;

        model_reset();
        #2;
        step();
        step();
        check("rst_count", 0, cnt[0], 0);
        check("rst_credits", 0, crd[0], 8);
        check("rst_out_valid", 0, ov[0], 0);
        check("rst_issue_ready", 0, ir[0], 1);
        check("rst_err", 0, er[0], 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Mid-stream reset: 5 issues, beats arrive 2 cycles later
        for (int i = 0; i < 5; i++) begin
            drive(1, (i >= 2), 8'(8'h20 + i), 0);
            step();
        end
        drive(0, 0, 8'h00, 0);
        check("mid_count", 0, cnt[0], 3);
        check("mid_credits", 0, crd[0], 3);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("arst_count", 0, cnt[0], 0);
        check("arst_credits", 0, crd[0], 8);
        check("arst_out_valid", 0, ov[0], 0);
        check("arst_issue_ready", 0, ir[0], 1);
        check("arst_err", 0, er[0], 0);
        step();
        rst = 1'b0;

        // Fill: 8 issues, beats 0x11..0x18 two cycles later, consumer stalled
        for (int i = 0; i < 10; i++) begin
            drive((i < 8), (i >= 2), 8'(8'h11 + i - 2), 0);
            step();
        end
        drive(0, 0, 8'h00, 0);
        check("fill_credits", 0, crd[0], 0);
        check("fill_issue_ready", 0, ir[0], 0);
        check("fill_count", 0, cnt[0], 8);
        check("fill_head", 0, od[0], 8'h11);

        // Issue without credit
        drive(1, 0, 8'h00, 0);
        step();
        drive(0, 0, 8'h00, 0);
        check("illegal_err", 0, er[0], ERR_ON);
        check("illegal_credits", 0, crd[0], 0);
        step();
        step();
        check("sticky_err", 0, er[0], ERR_ON);

        // Drain at one beat per cycle
        drive(0, 0, 8'h00, 1);
        for (int i = 0; i < 8; i++) begin
            #1;
            check("drain_valid", 0, ov[0], 1);
            check("drain_data", 0, od[0], 8'(8'h11 + i));
            step();
        end
        drive(0, 0, 8'h00, 0);
        check("drain_empty", 0, ov[0], 0);
        check("drain_credits", 0, crd[0], 8);
        check("drain_err_held", 0, er[0], ERR_ON);
        do_reset();
        check("err_cleared", 0, er[0], 0);

        // Wrap-around on DEPTH=5: 13 beats, random consumer
        sent  = 0;
        guard = 0;
        while ((sent < 13 || got.size() < 13) && guard < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 13) && ((m_cnt[1] < 5) || out_ready) &&
                        ($urandom_range(0, 3) != 0);
            in_data   = 8'(8'h40 + sent);
            #1;
            if (ov[1] && out_ready) got.push_back(od[1]);
            if (in_valid) sent++;
            step();
            guard++;
        end
        drive(0, 0, 8'h00, 0);
        check("wrap_beats", 1, got.size(), 13);
        for (int i = 0; i < got.size(); i++) check("wrap_order", 1, got[i], 8'(8'h40 + i));
        do_reset();

        // Simultaneous push and pop at full on DEPTH=4
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 8'(8'h01 + i), 0);
            step();
        end
        check("full4_count", 2, cnt[2], 4);
        drive(0, 1, 8'hAA, 1);
        #1 check("full4_head", 2, od[2], 8'h01);
        step();
        drive(0, 0, 8'h00, 0);
        check("full4_count_kept", 2, cnt[2], 4);
        check("full4_err", 2, er[2], 0);
        drive(0, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            #1 check("full4_order", 2, od[2], (i < 3) ? 8'(8'h02 + i) : 8'hAA);
            step();
        end
        drive(0, 0, 8'h00, 0);
        check("full4_empty", 2, ov[2], 0);
        do_reset();

        // Push into empty with consumer ready: no fall-through
        drive(0, 1, 8'h55, 1);
        #1 check("empty_no_fallthru", 0, ov[0], 0);
        step();
        drive(0, 0, 8'h00, 1);
        #1;
        check("empty_valid_next", 0, ov[0], 1);
        check("empty_data_next", 0, od[0], 8'h55);
        step();
        drive(0, 0, 8'h00, 0);
        check("empty_popped", 0, ov[0], 0);
        step();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
